// File: rtl/seq_booth_mul.sv
// Sequential radix-2 Booth multiplier producing the full 2*WIDTH-bit product.
// It handles signed and unsigned operands and retires one Booth step per clock.
module seq_booth_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW = 2*WIDTH + 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH:0]     a_q;
    logic [PW-1:0]      p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;

    logic               load, fin;
    logic [WIDTH:0]     a_ext, b_ext, upper;
    logic [PW-1:0]      p_step;

    // One extra operand bit lets a single Booth core cover both signednesses.
    assign a_ext = {is_signed & a[WIDTH-1], a};
    assign b_ext = {is_signed & b[WIDTH-1], b};

    always_comb begin
        upper = p_q[PW-1 -: WIDTH+1];
        case (p_q[1:0])
            2'b01:   upper = upper + a_q;
            2'b10:   upper = upper - a_q;
            default: upper = p_q[PW-1 -: WIDTH+1];
        endcase
        p_step = {upper[WIDTH], upper, p_q[WIDTH+1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (load) begin
            a_q   <= a_ext;
            p_q   <= {{(WIDTH+1){1'b0}}, b_ext, 1'b0};
            cnt_q <= CNT_W'(WIDTH+1);
        end else if (state == RUN) begin
            p_q   <= p_step;
            cnt_q <= cnt_q - CNT_W'(1);
            // Low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) product, after the last shift.
            if (fin) product_q <= p_step[2*WIDTH:1];
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_seq_booth_mul.sv
// Bench for seq_booth_mul: a WIDTH=32 instance for latency and corner checks,
// plus a WIDTH=8 instance exercised back-to-back with random operands.
module tb_seq_booth_mul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] p32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    seq_booth_mul #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .product(p32));

    seq_booth_mul #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(p8));

    int total  = 0;
    int passed = 0;
    int dones8 = 0;

    always @(negedge clk) if (done8) dones8++;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        bit          glitch;
        string       nm;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Product of the w-bit operands as plain integers, reduced to 2*w bits.
    function automatic logic [127:0] refmul(input int w, input logic s,
                                            input logic [63:0] x, input logic [63:0] y);
        logic [127:0] m, xe, ye, p;
        m  = (128'd1 << w) - 128'd1;
        xe = {64'd0, x} & m;
        ye = {64'd0, y} & m;
        if (s && x[w-1]) xe = xe | ~m;
        if (s && y[w-1]) ye = ye | ~m;
        p = xe * ye;
        return p & ((128'd1 << (2*w)) - 128'd1);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge following done.
    task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string nm, input bit glitch);
        int n, bc;
        logic [63:0] prev;
        bit held;
        prev = p32; held = 1'b1; bc = 0; n = 0;
        start32 = 1'b1; sgn32 = s; a32 = x; b32 = y;
        @(posedge clk); #1;
        start32 = 1'b0; sgn32 = ~s; a32 = $urandom; b32 = $urandom;
        while (!done32 && n < 60) begin
            if (busy32) bc++;
            if (p32 !== prev) held = 1'b0;
            start32 = glitch && n >= 4 && n <= 6;
            a32 = $urandom; b32 = $urandom;
            @(posedge clk); #1; n++;
        end
        start32 = 1'b0;
        check({nm, " latency"}, n, 33);
        check({nm, " busy_cycles"}, bc, 33);
        check({nm, " prev_held"}, held, 1);
        check({nm, " product"}, p32, exp);
        check({nm, " busy_in_done"}, busy32, 0);
        @(posedge clk); #1;
        check({nm, " done_one_cycle"}, done32, 0);
    endtask

    initial begin
        int n, nd;
        logic        s8;
        logic [7:0]  x8, y8;
        logic [15:0] e8;
        logic [31:0] x, y;
        logic        s;
        localparam int N8 = 400;

        tbl[0] = '{1'b1, 32'd7,          32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, "s_7xm3"};
        tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1, "u_ones"};
        tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, "s_minmin"};
        tbl[3] = '{1'b1, 32'd0,          32'h12345678, 64'd0,                 1'b0, "s_zero"};
        tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1,                 1'b1, "s_m1m1"};
        tbl[5] = '{1'b0, 32'h80000000, 32'd2,          64'h00000001_00000000, 1'b0, "u_2p32"};
        tbl[6] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0, "s_maxmin"};

        #12;
        check("rst busy32", busy32, 0);
        check("rst done32", done32, 0);
        check("rst prod32", p32, 0);
        check("rst busy8", busy8, 0);
        check("rst prod8", p8, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            op32(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm, tbl[i].glitch);

        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            op32(s, x, y, refmul(32, s, {32'd0, x}, {32'd0, y}), "rand32", i[0]);
        end

        // Asynchronous reset ten cycles into an operation.
        start32 = 1'b1; sgn32 = 1'b1; a32 = 32'd1234; b32 = 32'd5678;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst busy", busy32, 0);
        check("midrst done", done32, 0);
        check("midrst product", p32, 0);
        @(posedge clk); #1; rst = 1'b0;
        nd = 0;
        repeat (40) begin @(posedge clk); #1; if (done32 || busy32) nd++; end
        check("midrst no_activity", nd, 0);
        x = 32'hDEADBEEF; y = 32'h00C0FFEE;
        op32(1'b1, x, y, refmul(32, 1'b1, {32'd0, x}, {32'd0, y}), "post_rst", 1'b0);

        // WIDTH=8, back-to-back with start held high through each DONE cycle.
        dones8 = 0;
        s8 = 1'b1; x8 = 8'h80; y8 = 8'h80;
        e8 = refmul(8, s8, {56'd0, x8}, {56'd0, y8})[15:0];
        start8 = 1'b1; sgn8 = s8; a8 = x8; b8 = y8;
        for (int i = 0; i < N8; i++) begin
            @(posedge clk); #1;
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
            n = 0;
            while (!done8 && n < 30) begin @(posedge clk); #1; n++; end
            check("b2b8 latency", n, 9);
            check("b2b8 product", p8, e8);
            if (i < N8 - 1) begin
                case (i)
                    0:       begin s8 = 1'b0; x8 = 8'hFF; y8 = 8'hFF; end
                    1:       begin s8 = 1'b1; x8 = 8'h00; y8 = 8'h00; end
                    2:       begin s8 = 1'b1; x8 = 8'h7F; y8 = 8'h80; end
                    default: begin s8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); end
                endcase
                e8 = refmul(8, s8, {56'd0, x8}, {56'd0, y8})[15:0];
                start8 = 1'b1; sgn8 = s8; a8 = x8; b8 = y8;
            end
        end
        repeat (20) @(posedge clk);
        #1;
        check("b2b8 done_pulses", dones8, N8);
        check("b2b8 idle", busy8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seq_booth_mul.md
Name: seq_booth_mul

Overview:
Parametrised, multi-cycle radix-2 Booth multiplier. It is the sequential successor to the team's combinational 32-bit Booth multiplier and sits in the ALU execute path.
- Returns the full 2*WIDTH-bit product, not a truncated one.
- Supports signed and unsigned operands.
- Retires one Booth step per clock, trading latency for area.
- Uses a start/busy/done handshake toward the ALU control FSM.

Parameters:
WIDTH, 32, operand width in bits (legal range 4..64)
CNT_W, $clog2(WIDTH+2), iteration counter width (derived, do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; operands sampled on the edge where it is accepted
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
busy  output  1  high while a multiplication is in progress
done  output  1  one-cycle pulse, product valid
product  output  2*WIDTH  full product, held until next completion or reset

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, product=0, internal accumulator/counter cleared.
  - The in-flight operation is discarded; nothing is reported after reset releases.
- FSM has three states: IDLE, RUN, DONE.
- Accepting a request (IDLE or DONE, start=1):
  - Operands are extended to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - Registered as A (WIDTH+1 bits) and P = {(WIDTH+1) zeros, b_ext, 1'b0}, which is 2*WIDTH+3 bits.
  - Counter is loaded with WIDTH+1; next state is RUN; busy=1 from the next cycle.
- RUN, one Booth step per edge:
  - P[1:0]=01: upper WIDTH+1 bits += A.
  - P[1:0]=10: upper WIDTH+1 bits -= A.
  - 00 or 11: no add.
  - Then P is arithmetically shifted right by 1 (MSB replicated).
  - Arithmetic is modulo 2^(WIDTH+1) in the upper field.
  - Counter decrements each step.
- Final step (counter==1):
  - product is registered as P bits [2*WIDTH:1], taken after the shift, i.e. the low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) result.
  - done=1 for the following cycle; busy=0; state goes to DONE.
- Latency: the accept edge is edge 0; the product is written on edge WIDTH+1. For WIDTH=32, done is high in the cycle after edge 33.
- DONE state: done=1 for exactly one cycle. Next edge goes to IDLE, or back to RUN if start=1 (back-to-back accepted; done still pulses).
- start while busy=1 is ignored. Operands are not resampled and no error is flagged.
- a, b, is_signed may change freely after the accept edge without affecting the result.
- product changes only on the final-step edge or reset; it is stable during RUN of the next operation.
- Boundary cases:
  - Signed: most-negative x most-negative gives +2^(2*WIDTH-2), no overflow in 2*WIDTH bits.
  - Unsigned: all-ones x all-ones gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
  - Zero operands must still take the full WIDTH+1 cycles (fixed latency, no early termination).

Test Plan:
- WIDTH=32, signed: a=7, b=-3 (0xFFFFFFFD) -> done exactly 33 cycles after the accept edge; product=0xFFFFFFFF_FFFFFFEB (-21); busy high for 33 cycles.
- WIDTH=32, unsigned: a=b=0xFFFFFFFF -> product=0xFFFFFFFE_00000001. Then signed: a=b=0x80000000 -> product=0x40000000_00000000.
- WIDTH=8: exhaustive 65536 pairs in both modes against a reference model. Issue back-to-back, with start held high in the DONE cycle -> every result correct, no lost or duplicated done pulses.
- Start pulses during RUN with different operands -> ignored; product equals the first operation's result; operand changes after accept have no effect.
- Reset asserted asynchronously mid-RUN (cycle 10 of 33) -> busy, done, product go to 0 immediately. A new start after release completes correctly with full latency.
- a=0, b=0x12345678 signed -> product=0 after the full 33 cycles; the previous product is held unchanged until that edge.
